// File: rtl/link_motion_ctrl_if.sv
// Frame-timing, keycode and collision inputs plus motion outputs of link_motion_ctrl.
// master drives frame/key/collision; slave (the controller) drives dir/anim/move.
interface link_motion_ctrl_if;
  logic       frame_start;
  logic       frame_end;
  logic [7:0] keycode;
  logic       collision_in;
  logic [1:0] dir;
  logic       anim_frame;
  logic       moving;
  logic       blocked;
  logic       move_req;

  modport master (
    output frame_start, frame_end, keycode, collision_in,
    input  dir, anim_frame, moving, blocked, move_req
  );

  modport slave (
    input  frame_start, frame_end, keycode, collision_in,
    output dir, anim_frame, moving, blocked, move_req
  );
endinterface

// File: rtl/link_motion_ctrl.sv
// Per-frame Link motion sequencer: latches the key at frame start, and at frame end
// issues at most one move request and advances the walk-cycle animation.
module link_motion_ctrl #(
  parameter int unsigned ANIM_DIV = 8
) (
  input  logic               vga_clk,
  input  logic               reset,
  link_motion_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {STAND, WALK, BLOCK} state_e;

  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  function automatic logic is_dir_key(input logic [7:0] k);
    return (k == KEY_RIGHT) || (k == KEY_UP) || (k == KEY_LEFT) || (k == KEY_DOWN);
  endfunction

  function automatic logic [1:0] dir_of(input logic [7:0] k);
    logic [1:0] d;
    d = 2'd0;
    case (k)
      KEY_UP:    d = 2'd1;
      KEY_LEFT:  d = 2'd2;
      KEY_RIGHT: d = 2'd3;
      default:   d = 2'd0;
    endcase
    return d;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] key_q, key_d;
  logic       armed_q, armed_d;
  logic [1:0] dir_q, dir_d;
  logic [7:0] anim_cnt_q, anim_cnt_d;
  logic       anim_frame_q, anim_frame_d;
  logic       move_req_q, move_req_d;
  logic       key_valid;
  logic       eval;

  always_comb begin
    key_valid = is_dir_key(key_q);
    eval      = bus.frame_end & armed_q;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) state_q <= STAND;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (eval) begin
      if (!key_valid)            state_d = STAND;
      else if (bus.collision_in) state_d = BLOCK;
      else                       state_d = WALK;
    end
  end

  always_comb begin
    bus.moving     = (state_q == WALK);
    bus.blocked    = (state_q == BLOCK);
    bus.dir        = dir_q;
    bus.anim_frame = anim_frame_q;
    bus.move_req   = move_req_q;
  end

  // frame_end evaluation reads key_q before the frame_start update, so a
  // coincident pair moves with the old key and latches the new one together.
  always_comb begin
    key_d        = key_q;
    armed_d      = armed_q;
    dir_d        = dir_q;
    anim_cnt_d   = anim_cnt_q;
    anim_frame_d = anim_frame_q;
    move_req_d   = 1'b0;
    if (eval) begin
      if (!key_valid) begin
        anim_cnt_d   = '0;
        anim_frame_d = 1'b0;
      end else if (!bus.collision_in) begin
        move_req_d = 1'b1;
        if (anim_cnt_q == ANIM_LAST) begin
          anim_cnt_d   = '0;
          anim_frame_d = ~anim_frame_q;
        end else begin
          anim_cnt_d = anim_cnt_q + 8'd1;
        end
      end
    end
    if (bus.frame_start) begin
      key_d   = bus.keycode;
      armed_d = 1'b1;
      if (is_dir_key(bus.keycode)) dir_d = dir_of(bus.keycode);
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      key_q        <= '0;
      armed_q      <= 1'b0;
      dir_q        <= '0;
      anim_cnt_q   <= '0;
      anim_frame_q <= 1'b0;
      move_req_q   <= 1'b0;
    end else begin
      key_q        <= key_d;
      armed_q      <= armed_d;
      dir_q        <= dir_d;
      anim_cnt_q   <= anim_cnt_d;
      anim_frame_q <= anim_frame_d;
      move_req_q   <= move_req_d;
    end
  end
endmodule
